// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Drains an 8-bit FIFO one byte at a time and serialises each byte onto a
// UART line. The default frame is 8N1: start bit, data LSB first, stop bit.
// At most one byte is read from the FIFO per transmitted frame.
//
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
// between data bit 7 and the stop bit, giving 11-bit frames. With the macro
// undefined, the frame is the plain 10-bit 8N1 frame.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   tx_en       in   permission to start a new frame (sampled in IDLE only)
//   fifo_empty  in   FIFO empty flag
//   fifo_dout   in   FIFO read data, valid the cycle after a fifo_re pulse
//   fifo_re     out  FIFO read strobe, one-cycle pulse per byte (registered)
//   tx          out  serial line, idles high (registered)
//   busy        out  high in every state except IDLE
//   tx_done     out  one-cycle pulse on the last cycle of the stop bit
//   state_dbg   out  current FSM state, for debug and checker binding
//
// FIFO handshake: fifo_re is raised for exactly one cycle (the FETCH state),
// and only after IDLE has seen fifo_empty low. The FIFO presents the byte on
// fifo_dout during the following cycle (LOAD), and the shift register
// captures it on the closing edge of LOAD. fifo_empty is ignored in every
// other state, so a read is never issued against an empty FIFO.
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_re,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output logic [2:0] state_dbg
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif
    localparam logic [2:0] S_STOP   = 3'd6;

    logic [2:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              bit_end;
`ifdef UART_TX_PARITY_EN
    logic              parity;
`endif

    assign bit_end   = (baud_cnt == BAUD_MAX);
    assign busy      = (state != S_IDLE);
    assign tx_done   = (state == S_STOP) && bit_end;
    assign state_dbg = state;

    // tx and fifo_re are assigned together with the state transition that
    // enters the state they belong to, so both come straight from flops and
    // track the state register cycle for cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            fifo_re  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (tx_en && !fifo_empty) begin
                        state   <= S_FETCH;
                        fifo_re <= 1'b1;
                    end
                end

                S_FETCH: begin
                    fifo_re <= 1'b0;
                    state   <= S_LOAD;
                end

                S_LOAD: begin
                    shreg    <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                    parity   <= ^fifo_dout;
`endif
                    baud_cnt <= '0;
                    tx       <= 1'b0;
                    state    <= S_START;
                end

                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shreg[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity;
                            state <= S_PARITY;
`else
                            tx    <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            // Shift right at the boundary; the next bit to
                            // send is the current bit 1, i.e. the new bit 0.
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    fifo_re  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the 8-bit `fifo` block. It pulls bytes out of the FIFO one at a time through the FIFO's `re`/`empty`/`dout` handshake and serialises each byte onto a single UART line: 8N1 by default, with optional even parity. It sits between the FIFO and the chip's serial output pin. It paces FIFO reads so that exactly one byte is consumed per transmitted frame.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range is ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tx_en`  in  1  permission to start new frames; sampled only in IDLE.
- `fifo_empty`  in  1  connects to FIFO `empty`.
- `fifo_dout`  in  8  connects to FIFO `dout`; valid on the cycle after a `fifo_re` pulse.
- `fifo_re`  out  1  connects to FIFO `re`; a one-cycle pulse per byte.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high in every state except IDLE.
- `tx_done`  out  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY (present only with the macro), STOP.
- IDLE → FETCH when `tx_en && !fifo_empty`; otherwise stay in IDLE.
- FETCH lasts 1 cycle; `fifo_re` = 1 exactly in this state. Then → LOAD.
- LOAD lasts 1 cycle; the 8-bit shift register captures `fifo_dout` on its closing edge. Then → START.
- START: `tx` = 0 for `CLKS_PER_BIT` cycles. Then → DATA.
- DATA: 8 bits, LSB first, each held for `CLKS_PER_BIT` cycles.
  - A 3-bit bit counter selects the bit position.
  - The shift register shifts right at each bit boundary.
  - → PARITY or STOP after bit 7.
- PARITY: `tx` = XOR of the captured byte (even parity) for `CLKS_PER_BIT` cycles. Then → STOP.
- STOP: `tx` = 1 for `CLKS_PER_BIT` cycles; `tx_done` = 1 on the final cycle. Then → IDLE.
- Baud counter:
  - Width is `$clog2(CLKS_PER_BIT)`.
  - Cleared on entry to each bit state.
  - Counts 0..`CLKS_PER_BIT`-1.
  - The bit ends when the count reaches `CLKS_PER_BIT`-1.
- `tx_en` deasserted mid-frame: the frame completes normally; no further FETCH follows.
- `fifo_empty` is ignored outside IDLE. The block never pulses `re` on an empty FIFO.
- `tx` and `fifo_re` are registered outputs (state-decoded from flops), so the line is glitch-free.

## Timing
- Reset values (asynchronous, while `rst` is low): `tx` = 1, `busy` = 0, `fifo_re` = 0, `tx_done` = 0, state = IDLE, all counters and the shift register = 0.
- Reset mid-frame: `tx` goes high asynchronously and the in-flight byte is discarded; it is not re-read.
- Start-up latency: `fifo_empty` low is sampled in IDLE at edge 0. Then:
  - cycle 1: FETCH, with `fifo_re` = 1;
  - cycle 2: LOAD;
  - cycle 3: first cycle of the start bit (`tx` = 0).
- Frame length from START to end of STOP: 10·`CLKS_PER_BIT` cycles, or 11·`CLKS_PER_BIT` with parity.
- Back-to-back frames: exactly 3 `tx`-high cycles (IDLE, FETCH, LOAD) between the end of one stop bit and the next start bit.
- `busy` rises in the FETCH cycle and falls on the cycle after the final STOP cycle.
- The shift register loads exactly one byte per `fifo_re` pulse.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in. Every frame carries an even-parity bit between data bit 7 and stop, giving 11-bit frames.
- `UART_TX_PARITY_EN` undefined: the PARITY state and XOR logic are absent. DATA goes directly to STOP, giving 10-bit 8N1 frames.

## Test plan
- Reset:
  - Stimulus: hold `rst` = 0 for 3 cycles, with `fifo_empty` = 0 and `tx_en` = 1.
  - Required: `tx` = 1, `busy` = 0, `fifo_re` = 0 throughout.
  - Required after release: first `fifo_re` pulse exactly 1 cycle after IDLE samples non-empty.
- Single byte 8'hA5, `CLKS_PER_BIT` = 16, no parity:
  - Required `tx` sequence, 16 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1.
  - Required: exactly one `fifo_re` pulse; `tx_done` on cycle 160 after the start bit begins.
- FIFO filled with 0..15, `tx_en` = 1:
  - Required: 16 `fifo_re` pulses, frames decoded as 0x00..0x0F in order.
  - Required: a 3-cycle gap between consecutive frames, and no `re` once `empty` rises.
- `tx_en` behaviour:
  - Stimulus: `tx_en` = 0 with a non-empty FIFO for 100 cycles. Required: no `fifo_re` and `tx` constantly 1.
  - Stimulus: drop `tx_en` during DATA. Required: the current frame completes and no further fetch occurs.
- Reset mid-frame:
  - Stimulus: drive `rst` = 0 during data bit 3.
  - Required: `tx` goes to 1 immediately.
  - Required after release: the next byte is fetched with a fresh `fifo_re`, and the interrupted byte is never retransmitted.
- With `UART_TX_PARITY_EN` defined:
  - Byte 8'hA5: required parity bit 0.
  - Byte 8'h07: required parity bit 1.
  - Required: frame length 176 cycles, with `tx_done` on its last cycle.
